// File: rtl/mc_ctrlunit.sv
// Multi-cycle control unit for the 16-bit Subarashii core. It sequences FETCH/DECODE/EXEC/MEM/WB
// with a mem_ready handshake and an optional memory-wait timeout that raises bus_err.
module mc_ctrlunit #(
  parameter int OPW      = 4,
  parameter int MAX_WAIT = 15,
  parameter int WCW      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] instr_op,
  input  logic           zero,
  input  logic           mem_ready,
  output logic [2:0]     state,
  output logic           i_or_d,
  output logic           ir_write,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic [2:0]     alu_op,
  output logic [1:0]     alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     reg_dst,
  output logic [1:0]     mem_to_reg,
  output logic           mem_read,
  output logic           mem_write,
  output logic           reg_write,
  output logic           sign_ext,
  output logic           illegal,
  output logic           bus_err,
  output logic           instr_done
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ADI = 4'd8,
    OP_SWP = 4'd9,
    OP_LDW = 4'd10,
    OP_STW = 4'd11,
    OP_BRZ = 4'd12,
    OP_JAL = 4'd13
  } op_t;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       sext;
  } alu_ctl_t;

  localparam logic           TIMEOUT_EN = (MAX_WAIT > 0);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  state_t         state_q;
  state_t         next_state;
  logic [OPW-1:0] op_q;
  logic [WCW-1:0] wait_cnt;
  logic [31:0]    op_ext;
  logic [3:0]     op4;
  logic           legal;
  logic           is_ldw;
  logic           is_stw;
  logic           is_brz;
  logic           is_jal;
  logic           is_alu_wb;
  logic           timeout;
  alu_ctl_t       alu_c;

  // ALU ops 0000-0111 pass their low bits straight through; the rest use the fixed encodings.
  function automatic alu_ctl_t alu_decode(input logic [3:0] op);
    alu_ctl_t c;
    c = '0;
    if (!op[3]) begin
      c.op = op[2:0];
    end else begin
      case (op)
        OP_ADI:         c.src_b = 2'b01;
        OP_SWP:         begin c.src_a = 2'b10; c.src_b = 2'b10; end
        OP_LDW, OP_STW: c.src_a = 2'b11;
        OP_BRZ:         begin c.op = 3'b001; c.sext = 1'b1; end
        default:        c = '0;
      endcase
    end
    return c;
  endfunction

  assign op_ext    = 32'(op_q);
  assign op4       = op_ext[3:0];
  assign legal     = (op_ext <= 32'd13);
  assign is_ldw    = legal && (op4 == OP_LDW);
  assign is_stw    = legal && (op4 == OP_STW);
  assign is_brz    = legal && (op4 == OP_BRZ);
  assign is_jal    = legal && (op4 == OP_JAL);
  assign is_alu_wb = legal && (op4 <= OP_SWP);
  assign alu_c     = alu_decode(op4);
  assign timeout   = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT) && !mem_ready;

  assign state = rst ? S_FETCH : state_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state_q <= next_state;
      if (state_q == S_FETCH && mem_ready) begin
        op_q <= instr_op;
      end
      if (next_state != state_q || bus_err) begin
        wait_cnt <= '0;
      end else if (state_q == S_FETCH || state_q == S_MEM) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    next_state = state_q;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_op     = 3'b000;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    sign_ext   = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    instr_done = 1'b0;

    // Reset masks every strobe so an aborted memory access never leaks a write.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = S_DECODE;
          end else if (timeout) begin
            bus_err = 1'b1;
          end
        end

        S_DECODE: begin
          if (legal) begin
            next_state = S_EXEC;
          end else begin
            illegal    = 1'b1;
            next_state = S_FETCH;
          end
        end

        S_EXEC: begin
          alu_op    = alu_c.op;
          alu_src_a = alu_c.src_a;
          alu_src_b = alu_c.src_b;
          sign_ext  = alu_c.sext;
          if (is_ldw || is_stw) begin
            next_state = S_MEM;
          end else if (is_brz) begin
            pc_write   = zero;
            pc_src     = 2'b01;
            instr_done = 1'b1;
            next_state = S_FETCH;
          end else if (is_jal) begin
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end

        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = is_ldw;
          mem_write = is_stw;
          alu_op    = alu_c.op;
          alu_src_a = alu_c.src_a;
          alu_src_b = alu_c.src_b;
          sign_ext  = alu_c.sext;
          if (mem_ready) begin
            if (is_ldw) begin
              next_state = S_WB;
            end else begin
              instr_done = 1'b1;
              next_state = S_FETCH;
            end
          end else if (timeout) begin
            bus_err    = 1'b1;
            next_state = S_FETCH;
          end
        end

        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 2'b01;
          mem_to_reg = is_ldw ? 2'b01 : 2'b00;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end

        default: next_state = S_FETCH;
      endcase
    end
  end

  // Only used to document the one ALU/WB-class opcode set; keeps the decode self-describing.
  logic unused_alu_wb;
  assign unused_alu_wb = is_alu_wb;

endmodule

// File: tb/tb_mc_ctrlunit.sv
// Scoreboard bench for mc_ctrlunit: each instruction's expected retirement summary is computed
// from the ISA rules and queued; a monitor accumulates what the DUT did and compares on retirement.
`timescale 1ns/1ps
module tb_mc_ctrlunit;
  localparam int OPW = 4, MAX_WAIT = 15, WCW = 4;
  localparam logic [2:0] EV_DONE = 3'b100, EV_ILL = 3'b010, EV_ERR = 3'b001;

  logic clk, rst, zero, mem_ready;
  logic [OPW-1:0] instr_op;
  logic [2:0] state, alu_op;
  logic i_or_d, ir_write, pc_write, mem_read, mem_write, reg_write, sign_ext;
  logic illegal, bus_err, instr_done;
  logic [1:0] pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg;
  logic [22:0] outs;

  mc_ctrlunit #(.OPW(OPW), .MAX_WAIT(MAX_WAIT), .WCW(WCW)) dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .zero(zero), .mem_ready(mem_ready),
    .state(state), .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .sign_ext(sign_ext), .illegal(illegal), .bus_err(bus_err), .instr_done(instr_done)
  );

  assign outs = {i_or_d, ir_write, pc_write, pc_src, alu_op, alu_src_a, alu_src_b, reg_dst,
                 mem_to_reg, mem_read, mem_write, reg_write, sign_ext, illegal, bus_err, instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [2:0] ev;
    int cycles, ir_w, pc_w, reg_w, rd, wr, iord, ctl_n;
    logic [3:0] mux;
    logic [1:0] src;
    logic [7:0] ctl;
  } rec_t;

  rec_t exp_q[$];
  int n_cmp = 0, n_fail = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ALU control word {alu_op, src_a, src_b, sign_ext} the ISA table prescribes for EXEC.
  function automatic logic [7:0] exec_ctl(input logic [3:0] op);
    if (op < 4'd8) return {op[2:0], 5'b0};
    case (op)
      4'd8:        return 8'b000_00_01_0;
      4'd9:        return 8'b000_10_10_0;
      4'd10, 4'd11: return 8'b000_11_00_0;
      4'd12:       return 8'b001_00_00_1;
      default:     return 8'b0;
    endcase
  endfunction

  // Expected whole-instruction outcome for fetch wait fw and memory wait mw (wait > MAX_WAIT times out).
  function automatic rec_t model(input logic [3:0] op, input int fw, input int mw, input logic z);
    rec_t r;
    int mc;
    r = '{default: 0};
    r.op = op;
    if (fw > MAX_WAIT) begin
      r.ev = EV_ERR; r.cycles = MAX_WAIT + 1; r.rd = MAX_WAIT + 1;
      return r;
    end
    r.ir_w = 1; r.pc_w = 1; r.rd = fw + 1; r.cycles = fw + 2;
    if (op >= 4'd14) begin
      r.ev = EV_ILL;
      return r;
    end
    r.cycles += 1;
    r.ctl = exec_ctl(op);
    r.ctl_n = (r.ctl != 0) ? 1 : 0;
    r.ev = EV_DONE;
    if (op <= 4'd9) begin
      r.cycles += 1; r.reg_w = 1; r.mux = 4'b01_00;
    end else if (op == 4'd12) begin
      r.pc_w += int'(z); r.src = 2'b01;
    end else if (op == 4'd13) begin
      r.pc_w += 1; r.reg_w = 1; r.mux = 4'b10_10; r.src = 2'b10;
    end else begin
      mc = (mw > MAX_WAIT) ? MAX_WAIT + 1 : mw + 1;
      r.cycles += mc; r.iord = mc; r.ctl_n += mc;
      if (op == 4'd10) r.rd += mc; else r.wr = mc;
      if (mw > MAX_WAIT) begin
        r.ev = EV_ERR;
      end else if (op == 4'd10) begin
        r.cycles += 1; r.reg_w = 1; r.mux = 4'b01_01;
      end
    end
    return r;
  endfunction

  initial begin : monitor
    rec_t acc, e;
    logic [7:0] cur;
    acc = '{default: 0};
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        acc = '{default: 0};
      end else begin
        acc.cycles++;
        acc.ir_w += int'(ir_write); acc.pc_w += int'(pc_write); acc.reg_w += int'(reg_write);
        acc.rd += int'(mem_read); acc.wr += int'(mem_write); acc.iord += int'(i_or_d);
        cur = {alu_op, alu_src_a, alu_src_b, sign_ext};
        if (cur != 8'b0) acc.ctl_n++;
        acc.ctl |= cur;
        acc.mux |= {reg_dst, mem_to_reg};
        acc.src |= pc_src;
        acc.ev = {instr_done, illegal, bus_err};
        if (acc.ev != 3'b0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", 32'(acc.ev), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("op%0d_event", e.op), 32'(acc.ev), 32'(e.ev));
            check($sformatf("op%0d_cycles", e.op), acc.cycles, e.cycles);
            check($sformatf("op%0d_ir_write_cnt", e.op), acc.ir_w, e.ir_w);
            check($sformatf("op%0d_pc_write_cnt", e.op), acc.pc_w, e.pc_w);
            check($sformatf("op%0d_reg_write_cnt", e.op), acc.reg_w, e.reg_w);
            check($sformatf("op%0d_mem_read_cnt", e.op), acc.rd, e.rd);
            check($sformatf("op%0d_mem_write_cnt", e.op), acc.wr, e.wr);
            check($sformatf("op%0d_i_or_d_cnt", e.op), acc.iord, e.iord);
            check($sformatf("op%0d_wb_mux", e.op), 32'(acc.mux), 32'(e.mux));
            check($sformatf("op%0d_pc_src", e.op), 32'(acc.src), 32'(e.src));
            check($sformatf("op%0d_alu_ctl", e.op), 32'(acc.ctl), 32'(e.ctl));
            check($sformatf("op%0d_alu_ctl_cycles", e.op), acc.ctl_n, e.ctl_n);
          end
          acc = '{default: 0};
        end
      end
    end
  end

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return MAX_WAIT;
    if (r == 1) return MAX_WAIT + 1;
    if (r == 2) return MAX_WAIT - 1;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic cyc(input logic [3:0] op, input logic rdy, input logic z);
    instr_op = op; mem_ready = rdy; zero = z;
    @(posedge clk); #1;
  endtask

  // Drives one instruction's input timeline; opcode is only valid on the accepted fetch cycle.
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
    exp_q.push_back(model(op, fw, mw, z));
    if (fw > MAX_WAIT) begin
      repeat (MAX_WAIT + 1) cyc(rnd4(), 1'b0, rnd1());
      return;
    end
    repeat (fw) cyc(rnd4(), 1'b0, rnd1());
    cyc(op, 1'b1, rnd1());
    cyc(rnd4(), rnd1(), rnd1());
    if (op >= 4'd14) return;
    cyc(rnd4(), rnd1(), z);
    if (op == 4'd12 || op == 4'd13) return;
    if (op == 4'd10 || op == 4'd11) begin
      if (mw > MAX_WAIT) begin
        repeat (MAX_WAIT + 1) cyc(rnd4(), 1'b0, rnd1());
        return;
      end
      repeat (mw) cyc(rnd4(), 1'b0, rnd1());
      cyc(rnd4(), 1'b1, rnd1());
      if (op == 4'd11) return;
    end
    cyc(rnd4(), rnd1(), rnd1());
  endtask

  initial begin : stimulus
    rst = 1'b1; instr_op = 4'd0; mem_ready = 1'b1; zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'(outs), 32'd0);
      check("reset_state", 32'(state), 32'd0);
      instr_op = rnd4();
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    run_instr(4'd0, 0, 0, 1'b0);
    run_instr(4'd10, 0, 3, 1'b0);
    run_instr(4'd12, 0, 0, 1'b1);
    run_instr(4'd12, 0, 0, 1'b0);
    run_instr(4'd14, 0, 0, 1'b0);
    run_instr(4'd3, MAX_WAIT + 1, 0, 1'b0);
    run_instr(4'd13, MAX_WAIT, 0, 1'b0);
    run_instr(4'd11, 1, MAX_WAIT + 1, 1'b0);
    run_instr(4'd15, 2, 0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      run_instr(rnd4(), pick_wait(), pick_wait(), rnd1());
    end
    mon_en = 1'b0;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    // STW aborted by reset while waiting in MEM.
    cyc(4'd11, 1'b1, 1'b0);
    cyc(rnd4(), 1'b1, 1'b0);
    cyc(rnd4(), 1'b1, 1'b0);
    mem_ready = 1'b0;
    @(negedge clk);
    check("stw_mem_state", 32'(state), 32'd3);
    check("stw_mem_write", 32'(mem_write), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_rst_outputs", 32'(outs), 32'd0);
      check("abort_rst_state", 32'(state), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_state", 32'(state), 32'd0);
      check("post_rst_mem_write", 32'(mem_write), 32'd0);
      check("post_rst_mem_read", 32'(mem_read), 32'd1);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
